// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the Writeback
// stage and the MDU result FIFO. The pipeline has priority. A starvation
// counter force-grants the MDU head after STARVE_LIMIT denied cycles. A
// pending-destination mask is exported to the hazard unit.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_reg_write,
    input  logic [4:0]  W_rd_addr,
    input  logic [31:0] W_rd,
    input  logic        md_valid,
    input  logic [4:0]  md_rd_addr,
    input  logic [31:0] md_rd_data,
    output logic        md_ready,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] md_pending
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_PIPE,
        GNT_MDU
    } grant_e;

    logic [4:0]  mem_rd   [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [3:0]  starve_cnt;
    logic        empty, full, preq, mreq, head_nz, force_mdu, push, pop;
    grant_e      grant;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    assign count     = wptr - rptr;
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head_rd   = mem_rd[rptr[AW-1:0]];
    assign head_data = mem_data[rptr[AW-1:0]];

    assign preq      = W_reg_write && (W_rd_addr != 5'd0);
    assign mreq      = !empty;
    assign head_nz   = (head_rd != 5'd0);
    assign force_mdu = mreq && head_nz && (starve_cnt == LIMIT);

    // md_ready depends on occupancy only, so a full FIFO that pops this
    // cycle still refuses the offered result.
    assign md_ready  = !full;
    assign push      = md_valid && md_ready;
    assign wb_stall  = !rst && force_mdu && preq;

    // A head aimed at x0 is dropped without consuming the write port.
    assign pop       = !rst && ((grant == GNT_MDU) || (mreq && !head_nz));

    // Grant decision: forced MDU, then pipeline, then MDU into an idle slot.
    always_comb begin
        grant = GNT_IDLE;
        if (rst) begin
            grant = GNT_IDLE;
        end else if (force_mdu) begin
            grant = GNT_MDU;
        end else if (preq) begin
            grant = GNT_PIPE;
        end else if (mreq && head_nz) begin
            grant = GNT_MDU;
        end
    end

    // Register-file port mux driven from the grant.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        case (grant)
            GNT_PIPE: begin
                rf_we    = 1'b1;
                rf_waddr = W_rd_addr;
                rf_wdata = W_rd;
            end
            GNT_MDU: begin
                rf_we    = 1'b1;
                rf_waddr = head_rd;
                rf_wdata = head_data;
            end
            default: ;
        endcase
    end

    // Pending-destination mask: one-hot rd of every occupied FIFO slot.
    always_comb begin
        md_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((AW+1)'(k) < count) begin
                md_pending[mem_rd[rptr[AW-1:0] + AW'(k)]] = 1'b1;
            end
        end
        md_pending[0] = 1'b0;
    end

    // FIFO storage write on push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which slots are valid.
        if (push) begin
            mem_rd[wptr[AW-1:0]]   <= md_rd_addr;
            mem_data[wptr[AW-1:0]] <= md_rd_data;
        end
    end

    // Pointer and starvation-counter state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            starve_cnt <= 4'd0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if ((grant == GNT_MDU) || empty) begin
                starve_cnt <= 4'd0;
            end else if ((grant == GNT_PIPE) && head_nz && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DEPTH = 2, STARVE_LIMIT = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled 2 ns later.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        W_reg_write;
    logic [4:0]  W_rd_addr;
    logic [31:0] W_rd;
    logic        md_valid;
    logic [4:0]  md_rd_addr;
    logic [31:0] md_rd_data;
    logic        md_ready;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] md_pending;

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .W_reg_write(W_reg_write),
        .W_rd_addr  (W_rd_addr),
        .W_rd       (W_rd),
        .md_valid   (md_valid),
        .md_rd_addr (md_rd_addr),
        .md_rd_data (md_rd_data),
        .md_ready   (md_ready),
        .wb_stall   (wb_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .md_pending (md_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic st);
        check({tag, "_we"},    32'(rf_we),    32'(we));
        check({tag, "_addr"},  32'(rf_waddr), 32'(a));
        check({tag, "_data"},  rf_wdata,      d);
        check({tag, "_stall"}, 32'(wb_stall), 32'(st));
    endtask

    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];

    initial begin
        int p;
        bit full_checked;

        // ---- Reset with both requesters active ----
        rst = 1'b1; W_reg_write = 1'b1; W_rd_addr = 5'd5; W_rd = 32'hDEADBEEF;
        md_valid = 1'b1; md_rd_addr = 5'd17; md_rd_data = 32'h1111_2222;
        for (int c = 0; c < 2; c++) begin
            tick(); settle();
            check_port("rst", 1'b0, 5'd0, 32'd0, 1'b0);
            check("rst_ready",   32'(md_ready), 32'd1);
            check("rst_pending", md_pending,    32'd0);
        end
        tick();
        rst = 1'b0; md_valid = 1'b0;
        settle();
        check_port("post_rst_x5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        check("post_rst_pending", md_pending, 32'd0);

        // ---- MDU only ----
        tick();
        W_reg_write = 1'b0; md_valid = 1'b1; md_rd_addr = 5'd7; md_rd_data = 32'h12345678;
        settle();
        check_port("mdu_push", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        md_valid = 1'b0;
        settle();
        check_port("mdu_write", 1'b1, 5'd7, 32'h12345678, 1'b0);
        check("mdu_pending_set", md_pending, 32'h0000_0080);
        tick(); settle();
        check("mdu_pending_clr", md_pending, 32'd0);
        check("mdu_idle_we", 32'(rf_we), 32'd0);

        // ---- Contention and starvation force ----
        tick();
        W_reg_write = 1'b1; W_rd_addr = 5'd9; W_rd = 32'hA5A5_0009;
        md_valid = 1'b1; md_rd_addr = 5'd3; md_rd_data = 32'h3333_3333;
        settle();
        check_port("cont_push", 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
        tick();
        md_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            check_port($sformatf("cont_pipe%0d", i), 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
            tick();
        end
        settle();
        check_port("cont_force", 1'b1, 5'd3, 32'h3333_3333, 1'b1);
        tick(); settle();
        check_port("cont_held", 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
        check("cont_pending", md_pending, 32'd0);
        // A fresh result must again wait the full 4 cycles, proving the counter cleared.
        md_valid = 1'b1; md_rd_addr = 5'd8; md_rd_data = 32'h8888_0008;
        tick();
        md_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            check_port($sformatf("cont2_pipe%0d", i), 1'b1, 5'd9, 32'hA5A5_0009, 1'b0);
            tick();
        end
        settle();
        check_port("cont2_force", 1'b1, 5'd8, 32'h8888_0008, 1'b1);
        tick();

        // ---- FIFO full with continuous pipeline writes ----
        W_rd_addr = 5'd10; W_rd = 32'h1010_1010;
        p = 0; full_checked = 1'b0;
        for (int c = 0; c < 40; c++) begin
            md_valid   = (p < 3);
            md_rd_addr = 5'(11 + p);
            md_rd_data = 32'hD000_0000 + 32'(p);
            settle();
            if (p == 2 && !full_checked) begin
                check("full_ready_low", 32'(md_ready), 32'd0);
                check("full_pending", md_pending, 32'h0000_1800);
                full_checked = 1'b1;
            end
            if (rf_we && rf_waddr == 5'd10) begin
                if (rf_wdata !== 32'h1010_1010) check("full_pipe_data", rf_wdata, 32'h1010_1010);
            end else if (rf_we) begin
                got_addr.push_back(rf_waddr);
                got_data.push_back(rf_wdata);
            end
            if (md_valid && md_ready) p++;
            tick();
        end
        check("full_pushes", 32'(p), 32'd3);
        check("full_writes", 32'(got_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_addr.size()) begin
                check($sformatf("full_order_addr%0d", i), 32'(got_addr[i]), 32'(11 + i));
                check($sformatf("full_order_data%0d", i), got_data[i], 32'hD000_0000 + 32'(i));
            end
        end
        md_valid = 1'b0;
        settle();
        check("full_drained_pending", md_pending, 32'd0);
        check("full_drained_ready", 32'(md_ready), 32'd1);

        // ---- x0 handling ----
        tick();
        W_rd_addr = 5'd0; W_rd = 32'hFFFF_0000;
        settle();
        check_port("x0_pipe", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        md_valid = 1'b1; md_rd_addr = 5'd0; md_rd_data = 32'h0BAD_0BAD;
        tick();
        md_valid = 1'b0; W_rd_addr = 5'd4; W_rd = 32'h4444_4444;
        settle();
        check_port("x0_mdu_pipe4", 1'b1, 5'd4, 32'h4444_4444, 1'b0);
        check("x0_pending", md_pending, 32'd0);
        tick();
        W_reg_write = 1'b0; md_valid = 1'b1; md_rd_addr = 5'd6; md_rd_data = 32'h6666_6666;
        tick();
        md_valid = 1'b0;
        settle();
        check_port("x0_then_x6", 1'b1, 5'd6, 32'h6666_6666, 1'b0);

        // ---- Reset mid-drain ----
        tick();
        W_reg_write = 1'b1; W_rd_addr = 5'd10; W_rd = 32'h1010_1010;
        md_valid = 1'b1; md_rd_addr = 5'd20; md_rd_data = 32'h2020_2020;
        tick();
        md_rd_addr = 5'd21; md_rd_data = 32'h2121_2121;
        tick();
        md_valid = 1'b0;
        settle();
        check("mid_pending", md_pending, 32'h0030_0000);
        check("mid_ready",   32'(md_ready), 32'd0);
        tick();
        rst = 1'b1;
        settle();
        check_port("mid_rst", 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        rst = 1'b0; W_reg_write = 1'b0;
        settle();
        check("mid_after_pending", md_pending, 32'd0);
        check("mid_after_ready",   32'(md_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("mid_no_write%0d", c), 32'(rf_we), 32'd0);
            tick(); settle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
